// File: rtl/fsic_serdes_link_ctrl.sv
// fsic_serdes_link_ctrl
// AXI-Lite master sequencer that brings up the IO serdes link: writes rxen
// (0x1) to the serdes control register, waits a programmable guard time,
// writes txen (0x3), then optionally reads the register back to confirm.
//
// Build option:
//   FSIC_LINK_CTRL_READBACK_EN - when defined, the txen write is followed by
//   a readback of offset 0; a value without both enables set triggers a
//   retry of the txen write (up to pMAX_RETRY times). When undefined, the
//   txen write completion finishes the sequence and the read channel is idle.
module fsic_serdes_link_ctrl #(
    parameter int pADDR_WIDTH = 10,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255,
    parameter int pMAX_RETRY  = 3
) (
    input  logic                     axi_clk,
    input  logic                     axi_reset_n,
    input  logic                     start,
    input  logic [15:0]              guard_cycles,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cc_is_enable,
    output logic                     m_awvalid,
    output logic [pADDR_WIDTH-1:0]   m_awaddr,
    input  logic                     m_awready,
    output logic                     m_wvalid,
    output logic [pDATA_WIDTH-1:0]   m_wdata,
    output logic [pDATA_WIDTH/8-1:0] m_wstrb,
    input  logic                     m_wready,
    output logic                     m_arvalid,
    output logic [pADDR_WIDTH-1:0]   m_araddr,
    input  logic                     m_arready,
    input  logic                     m_rvalid,
    input  logic [pDATA_WIDTH-1:0]   m_rdata,
    output logic                     m_rready
);

    localparam int         SW       = pDATA_WIDTH / 8;
    // Wait counter value at which the next pending cycle would hit the limit
    localparam logic [7:0] TMO_LAST = 8'(pTIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_RX, S_GUARD, S_WR_TX, S_RD_ADDR, S_RD_DATA, S_DONE, S_ERR
    } state_t;

    state_t      state, state_n;
    logic        aw_ok, w_ok;        // channel already handshaked in this write
    logic [15:0] guard_lat, guard_cnt;
    logic [7:0]  wait_cnt;
    logic        done_q, error_q;
    logic        wr_st, aw_fin, w_fin, tmo, pending;

`ifdef FSIC_LINK_CTRL_READBACK_EN
    localparam int RW = (pMAX_RETRY < 1) ? 1 : $clog2(pMAX_RETRY + 1);
    logic [RW-1:0] retry_cnt;
    logic          unused_rdata;
    assign unused_rdata = ^m_rdata[pDATA_WIDTH-1:2];
`else
    logic          unused_rd;
    assign unused_rd = ^{m_arready, m_rvalid, m_rdata};
`endif

    assign wr_st   = (state == S_WR_RX) || (state == S_WR_TX);
    assign aw_fin  = aw_ok || (m_awvalid && m_awready);
    assign w_fin   = w_ok  || (m_wvalid  && m_wready);
    assign tmo     = (wait_cnt == TMO_LAST);
    assign pending = wr_st || (state == S_RD_ADDR) || (state == S_RD_DATA);

    // AXI channel drive: valids derive from state and per-channel done flags
    assign m_awvalid = wr_st && !aw_ok;
    assign m_wvalid  = wr_st && !w_ok;
    assign m_awaddr  = '0;
    assign m_araddr  = '0;
    assign m_wdata   = !m_wvalid ? '0 :
                       (state == S_WR_TX) ? pDATA_WIDTH'(3) : pDATA_WIDTH'(1);
    assign m_wstrb   = m_wvalid ? SW'(1) : '0;
`ifdef FSIC_LINK_CTRL_READBACK_EN
    assign m_arvalid = (state == S_RD_ADDR);
    assign m_rready  = (state == S_RD_DATA);
`else
    assign m_arvalid = 1'b0;
    assign m_rready  = 1'b0;
`endif
    assign cc_is_enable = m_awvalid || m_wvalid || m_arvalid || m_rready;
    assign busy         = (state != S_IDLE);
    assign done         = done_q;
    assign error        = error_q;

    // State register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= S_IDLE;
        else              state <= state_n;
    end

    // Next-state logic; completion takes priority over timeout
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_WR_RX;
            S_WR_RX: begin
                if (aw_fin && w_fin)
                    state_n = (guard_lat == 16'd0) ? S_WR_TX : S_GUARD;
                else if (tmo)
                    state_n = S_ERR;
            end
            S_GUARD: if (guard_cnt == 16'd0) state_n = S_WR_TX;
            S_WR_TX: begin
                if (aw_fin && w_fin)
`ifdef FSIC_LINK_CTRL_READBACK_EN
                    state_n = S_RD_ADDR;
`else
                    state_n = S_DONE;
`endif
                else if (tmo)
                    state_n = S_ERR;
            end
`ifdef FSIC_LINK_CTRL_READBACK_EN
            S_RD_ADDR: begin
                if (m_arready)  state_n = S_RD_DATA;
                else if (tmo)   state_n = S_ERR;
            end
            S_RD_DATA: begin
                if (m_rvalid) begin
                    if (m_rdata[1:0] == 2'b11)           state_n = S_DONE;
                    else if (retry_cnt == RW'(pMAX_RETRY)) state_n = S_ERR;
                    else                                 state_n = S_WR_TX;
                end else if (tmo) begin
                    state_n = S_ERR;
                end
            end
`endif
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Handshake tracking and wait counter; both restart on every state entry
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            wait_cnt <= 8'd0;
        end else if (state_n != state) begin
            aw_ok    <= 1'b0;
            w_ok     <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            if (m_awvalid && m_awready) aw_ok <= 1'b1;
            if (m_wvalid && m_wready)   w_ok  <= 1'b1;
            if (pending)                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Guard latch and down-counter; GUARD lasts exactly guard_lat cycles
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            guard_lat <= 16'd0;
            guard_cnt <= 16'd0;
        end else begin
            if (state == S_IDLE && start) guard_lat <= guard_cycles;
            if (state == S_WR_RX && state_n == S_GUARD)
                guard_cnt <= guard_lat - 16'd1;
            else if (state == S_GUARD && guard_cnt != 16'd0)
                guard_cnt <= guard_cnt - 16'd1;
        end
    end

    // Sticky status: cleared by an accepted start, set on entry to DONE/ERR
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                done_q  <= 1'b0;
                error_q <= 1'b0;
            end
            if (state_n == S_DONE && state != S_DONE) done_q  <= 1'b1;
            if (state_n == S_ERR  && state != S_ERR)  error_q <= 1'b1;
        end
    end

`ifdef FSIC_LINK_CTRL_READBACK_EN
    // Readback retry counter
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n)
            retry_cnt <= '0;
        else if (state == S_IDLE && start)
            retry_cnt <= '0;
        else if (state == S_RD_DATA && state_n == S_WR_TX)
            retry_cnt <= retry_cnt + RW'(1);
    end
`endif

endmodule

// File: tb/tb_fsic_serdes_link_ctrl.sv
// Directed bench for fsic_serdes_link_ctrl with a reactive AXI-Lite slave.
module tb_fsic_serdes_link_ctrl;

    localparam int TMO = 255;

    logic        axi_clk = 1'b0;
    logic        axi_reset_n;
    logic        start;
    logic [15:0] guard_cycles;
    logic        busy, done, error, cc_is_enable;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [9:0]  m_awaddr, m_araddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int vectors = 0, errors = 0;
    int cyc = 0;
    // slave-owned counters
    int aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, aw_c = 0, w_c = 0, aw_drop = 0, bad_bus = 0;
    bit aw_pend = 1'b0;
    logic [31:0] w_log [64];
    int          w_cyc [64];
    // stimulus-owned slave configuration
    int aw_lat, w_lat, rd_base;
    bit aw_blk, ar_blk;
    logic [31:0] rd_q [8];

`ifdef FSIC_LINK_CTRL_READBACK_EN
    wire blocked_valid = m_arvalid;
`else
    wire blocked_valid = m_awvalid;
`endif

    fsic_serdes_link_ctrl dut (
        .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .start(start),
        .guard_cycles(guard_cycles), .busy(busy), .done(done), .error(error),
        .cc_is_enable(cc_is_enable),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
    );

    always #5 axi_clk = ~axi_clk;
    always @(posedge axi_clk) cyc <= cyc + 1;

    // Slave: readies set on the falling edge, handshakes logged for the next rising edge
    always @(negedge axi_clk) begin
        int ri;
        if (m_awvalid) begin m_awready = !aw_blk && (aw_c >= aw_lat); aw_c++; end
        else begin m_awready = 1'b0; aw_c = 0; end
        if (m_wvalid) begin m_wready = (w_c >= w_lat); w_c++; end
        else begin m_wready = 1'b0; w_c = 0; end
        m_arready = m_arvalid && !ar_blk;
        ri = r_n - rd_base;
        if (ri > 7) ri = 7;
        if (ri < 0) ri = 0;
        m_rvalid = 1'b1;
        m_rdata  = rd_q[ri];
        if (aw_pend && !m_awvalid) aw_drop++;
        aw_pend = m_awvalid && !m_awready;
        if (m_awvalid && m_awready) aw_n++;
        if (m_wvalid && m_wready) begin
            w_log[w_n % 64] = m_wdata;
            w_cyc[w_n % 64] = cyc;
            if (m_wstrb != 4'b0001 || m_awaddr != 10'd0) bad_bus++;
            w_n++;
        end
        if (m_arvalid && m_arready) ar_n++;
        if (m_rvalid && m_rready) r_n++;
    end

    task automatic pulse_start(input logic [15:0] g);
        @(negedge axi_clk);
        guard_cycles = g;
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin @(negedge axi_clk); n++; end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_wait busy=%b want 0", busy); end
    endtask

    task automatic test_reset();
        axi_reset_n = 1'b1;
        #2 axi_reset_n = 1'b0;
        repeat (2) @(negedge axi_clk);
        vectors++;
        if ({busy, done, error, cc_is_enable} !== 4'b0000) begin
            errors++; $display("FAIL reset_status got %b want 0000", {busy, done, error, cc_is_enable});
        end
        vectors++;
        if ({m_awvalid, m_wvalid, m_arvalid, m_rready} !== 4'b0000) begin
            errors++; $display("FAIL reset_valids got %b want 0000", {m_awvalid, m_wvalid, m_arvalid, m_rready});
        end
        vectors++;
        if ({m_wstrb, m_wdata} !== 36'd0) begin
            errors++; $display("FAIL reset_wbus got %h/%h want 0/0", m_wstrb, m_wdata);
        end
        axi_reset_n = 1'b1;
        repeat (2) @(negedge axi_clk);
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_start busy=%b want 0", busy); end
    endtask

    task automatic test_basic();
        logic [15:0] gs [3];
        gs = '{16'd4, 16'd0, 16'd1};
        for (int k = 0; k < 3; k++) begin
            int bw = w_n, baw = aw_n, br = r_n, n = 0, dc = -1, bc;
            pulse_start(gs[k]);
            while (busy && n < 2000) begin
                if (done && dc < 0) dc = cyc;
                @(negedge axi_clk); n++;
            end
            bc = cyc;
            vectors++;
            if (busy !== 1'b0) begin errors++; $display("FAIL basic_end g=%0d busy=%b want 0", gs[k], busy); end
            vectors++;
            if (w_n - bw != 2 || aw_n - baw != 2) begin
                errors++; $display("FAIL basic_writes g=%0d aw=%0d w=%0d want 2/2", gs[k], aw_n - baw, w_n - bw);
            end
            vectors++;
            if (w_log[bw % 64] !== 32'h1 || w_log[(bw + 1) % 64] !== 32'h3) begin
                errors++; $display("FAIL basic_wdata g=%0d got %h,%h want 1,3", gs[k], w_log[bw % 64], w_log[(bw + 1) % 64]);
            end
            vectors++;
            if (w_cyc[(bw + 1) % 64] - w_cyc[bw % 64] != int'(gs[k]) + 1) begin
                errors++; $display("FAIL basic_guard g=%0d spacing %0d want %0d", gs[k],
                                   w_cyc[(bw + 1) % 64] - w_cyc[bw % 64], int'(gs[k]) + 1);
            end
            vectors++;
            if ({done, error} !== 2'b10) begin
                errors++; $display("FAIL basic_status g=%0d done/error=%b want 10", gs[k], {done, error});
            end
            vectors++;
            if (bc - dc != 1) begin errors++; $display("FAIL basic_busy_fall g=%0d delta=%0d want 1", gs[k], bc - dc); end
`ifdef FSIC_LINK_CTRL_READBACK_EN
            vectors++;
            if (r_n - br != 1) begin errors++; $display("FAIL basic_reads g=%0d got %0d want 1", gs[k], r_n - br); end
`else
            vectors++;
            if (r_n - br != 0) begin errors++; $display("FAIL basic_reads g=%0d got %0d want 0", gs[k], r_n - br); end
`endif
        end
        vectors++;
        if (bad_bus != 0) begin errors++; $display("FAIL wstrb_addr bad=%0d want 0", bad_bus); end
    endtask

    task automatic test_split();
        int bw = w_n, baw = aw_n, bd = aw_drop;
        aw_lat = 3; w_lat = 1;
        pulse_start(16'd4);
        @(negedge axi_clk);
        vectors++;
        if ({m_awvalid, m_wvalid} !== 2'b11) begin
            errors++; $display("FAIL split_cyc1 aw/w=%b want 11", {m_awvalid, m_wvalid});
        end
        @(negedge axi_clk);
        vectors++;
        if ({m_awvalid, m_wvalid} !== 2'b10) begin
            errors++; $display("FAIL split_cyc2 aw/w=%b want 10", {m_awvalid, m_wvalid});
        end
        wait_idle(2000);
        vectors++;
        if (w_n - bw != 2 || aw_n - baw != 2 || aw_drop - bd != 0) begin
            errors++; $display("FAIL split_writes aw=%0d w=%0d drops=%0d want 2/2/0", aw_n - baw, w_n - bw, aw_drop - bd);
        end
        vectors++;
        if ({done, error} !== 2'b10) begin errors++; $display("FAIL split_status got %b want 10", {done, error}); end
        aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_busy_start();
        int bw = w_n;
        pulse_start(16'd10);
        vectors++;
        if ({busy, done, error} !== 3'b100) begin
            errors++; $display("FAIL start_clears got %b want 100", {busy, done, error});
        end
        repeat (4) @(negedge axi_clk);
        start = 1'b1;
        @(negedge axi_clk);
        start = 1'b0;
        wait_idle(2000);
        vectors++;
        if (w_n - bw != 2) begin errors++; $display("FAIL busy_start_writes got %0d want 2", w_n - bw); end
        repeat (3) @(negedge axi_clk);
        vectors++;
        if ({busy, done} !== 2'b01) begin errors++; $display("FAIL busy_start_queued busy/done=%b want 01", {busy, done}); end
    endtask

    task automatic test_timeout();
        int n = 0, bh = aw_n + ar_n;
`ifdef FSIC_LINK_CTRL_READBACK_EN
        ar_blk = 1'b1;
`else
        aw_blk = 1'b1;
`endif
        pulse_start(16'd2);
        while (!blocked_valid && n < 100) begin @(negedge axi_clk); n++; end
        n = 0;
        while (!error && n < TMO + 50) begin @(negedge axi_clk); n++; end
        vectors++;
        if (n != TMO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", n, TMO); end
        vectors++;
        if ({blocked_valid, cc_is_enable, done} !== 3'b000) begin
            errors++; $display("FAIL timeout_drop valid/cc/done=%b want 000", {blocked_valid, cc_is_enable, done});
        end
        wait_idle(10);
        vectors++;
        if (aw_n + ar_n != bh + 0 || blocked_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_after hs=%0d valid=%b want 0/0", aw_n + ar_n - bh, blocked_valid);
        end
        aw_blk = 1'b0; ar_blk = 1'b0;
    endtask

`ifdef FSIC_LINK_CTRL_READBACK_EN
    task automatic test_mismatch();
        for (int k = 0; k < 2; k++) begin
            int bw = w_n, br = r_n;
            for (int i = 0; i < 8; i++) rd_q[i] = (k == 0 && i >= 3) ? 32'h3 : 32'h1;
            rd_base = r_n;
            pulse_start(16'd0);
            wait_idle(3000);
            vectors++;
            if (r_n - br != 4 || w_n - bw != 5) begin
                errors++; $display("FAIL mismatch_counts k=%0d reads=%0d writes=%0d want 4/5", k, r_n - br, w_n - bw);
            end
            vectors++;
            if ({done, error} !== ((k == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL mismatch_status k=%0d got %b want %b", k, {done, error}, (k == 0) ? 2'b10 : 2'b01);
            end
        end
        for (int i = 0; i < 8; i++) rd_q[i] = 32'h3;
    endtask
`endif

    task automatic test_reset_guard();
        int bw;
        pulse_start(16'd30);
        repeat (5) @(negedge axi_clk);
        vectors++;
        if ({busy, m_awvalid, m_wvalid} !== 3'b100) begin
            errors++; $display("FAIL guard_phase busy/aw/w=%b want 100", {busy, m_awvalid, m_wvalid});
        end
        #2 axi_reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, error, cc_is_enable, m_awvalid, m_wvalid, m_arvalid, m_rready} !== 8'd0) begin
            errors++; $display("FAIL reset_mid_guard got %b want 00000000",
                               {busy, done, error, cc_is_enable, m_awvalid, m_wvalid, m_arvalid, m_rready});
        end
        @(negedge axi_clk);
        axi_reset_n = 1'b1;
        bw = w_n;
        pulse_start(16'd2);
        vectors++;
        if ({m_awvalid, m_wvalid} !== 2'b11 || m_wdata !== 32'h1) begin
            errors++; $display("FAIL restart_wr_rx aw/w=%b wdata=%h want 11/1", {m_awvalid, m_wvalid}, m_wdata);
        end
        wait_idle(2000);
        vectors++;
        if (w_n - bw != 2 || w_log[bw % 64] !== 32'h1 || w_log[(bw + 1) % 64] !== 32'h3 ||
            w_cyc[(bw + 1) % 64] - w_cyc[bw % 64] != 3) begin
            errors++; $display("FAIL restart_seq writes=%0d data=%h,%h spacing=%0d want 2/1,3/3", w_n - bw,
                               w_log[bw % 64], w_log[(bw + 1) % 64], w_cyc[(bw + 1) % 64] - w_cyc[bw % 64]);
        end
        vectors++;
        if ({done, error} !== 2'b10) begin errors++; $display("FAIL restart_status got %b want 10", {done, error}); end
    endtask

    initial begin
        start = 1'b0; guard_cycles = 16'd0;
        aw_lat = 0; w_lat = 0; aw_blk = 1'b0; ar_blk = 1'b0; rd_base = 0;
        for (int i = 0; i < 8; i++) rd_q[i] = 32'h3;
        test_reset();
        test_basic();
        test_split();
        test_busy_start();
        test_timeout();
`ifdef FSIC_LINK_CTRL_READBACK_EN
        test_mismatch();
`endif
        test_reset_guard();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
